timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// Four-channel tick-based countdown timer. A free-running prescaler produces a
// tick; after each tick a 4-cycle sweep decrements one running channel per cycle.
module timer_scheduler #(
    parameter int PRESCALE = 50000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_ch,
    input  logic [15:0] cmd_val,
    output logic        cmd_ready,
    output logic        tick,
    output logic [3:0]  busy,
    output logic [3:0]  done,
    output logic [3:0]  expire
);

    localparam int          NUM_CH        = 4;
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic {
        ST_WAIT,
        ST_SWEEP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_DONE
    } ch_state_t;

    // ------------------------------------------------------------------
    // Prescaler: tick is a decode of the counter, so it is low in reset.
    // ------------------------------------------------------------------
    logic [15:0] presc_reg;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (presc_reg == PRESCALE_LAST) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

    assign tick = (presc_reg == PRESCALE_LAST);

    // ------------------------------------------------------------------
    // Control FSM: WAIT accepts commands, SWEEP visits slots 0..3.
    // ------------------------------------------------------------------
    ctrl_state_t ctrl_reg;
    logic [1:0]  slot_reg;
    logic        cmd_ready_reg;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ctrl_reg      <= ST_WAIT;
            slot_reg      <= 2'd0;
            cmd_ready_reg <= 1'b1;
        end else begin
            case (ctrl_reg)
                ST_WAIT: begin
                    if (tick) begin
                        ctrl_reg      <= ST_SWEEP;
                        slot_reg      <= 2'd0;
                        cmd_ready_reg <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    slot_reg <= slot_reg + 2'd1;
                    if (slot_reg == 2'd3) begin
                        ctrl_reg      <= ST_WAIT;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    ctrl_reg      <= ST_WAIT;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;

    logic cmd_fire;
    logic sweep_active;

    assign cmd_fire     = cmd_valid && cmd_ready_reg;
    assign sweep_active = (ctrl_reg == ST_SWEEP);

    // ------------------------------------------------------------------
    // Channels. Commands and sweep slots never coincide because commands
    // are only accepted in WAIT.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] expire_next;
    logic [NUM_CH-1:0] expire_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_t   state_reg;
            ch_state_t   state_next;
            logic [15:0] count_reg;
            logic [15:0] count_next;
            logic        cmd_hit;
            logic        slot_hit;
            logic        ch_expire;

            assign cmd_hit  = cmd_fire && (cmd_ch == 2'(gi));
            assign slot_hit = sweep_active && (slot_reg == 2'(gi)) && (state_reg == CH_RUN);

            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                ch_expire  = 1'b0;
                if (cmd_hit) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            if (cmd_val == 16'd0) begin
                                count_next = 16'd0;
                                state_next = CH_DONE;
                                ch_expire  = 1'b1;
                            end else begin
                                count_next = cmd_val;
                                state_next = CH_RUN;
                            end
                        end
                        OP_STOP: begin
                            state_next = CH_IDLE;
                        end
                        OP_CLEAR: begin
                            if (state_reg == CH_DONE) begin
                                state_next = CH_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end else if (slot_hit) begin
                    // A running count is never 0, so anything <=1 is the last tick.
                    if (count_reg > 16'd1) begin
                        count_next = count_reg - 16'd1;
                    end else begin
                        count_next = 16'd0;
                        state_next = CH_DONE;
                        ch_expire  = 1'b1;
                    end
                end
            end

            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    state_reg <= CH_IDLE;
                    count_reg <= 16'd0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                end
            end

            assign expire_next[gi] = ch_expire;
            assign busy[gi]        = (state_reg == CH_RUN);
            assign done[gi]        = (state_reg == CH_DONE);
        end
    endgenerate

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            expire_reg <= '0;
        end else begin
            expire_reg <= expire_next;
        end
    end

    assign expire = expire_reg;

endmodule
